// File: rtl/i2s_mic_frontend.sv
`default_nettype none
// ============================================================================
// Module      : i2s_mic_frontend
// Description : I2S master for a stereo MEMS microphone pair on one data line.
//               Generates SCK/WS and presents each left/right pair with a
//               one-clock valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_mic_frontend #(
    parameter int SCK_HALF     = 16,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    mic_data,
    output logic                    mic_sck,
    output logic                    mic_ws,
    output logic [SAMPLE_WIDTH-1:0] audio_left,
    output logic [SAMPLE_WIDTH-1:0] audio_right,
    output logic                    audio_valid
);

    localparam int                 c_DIV_W    = $clog2(SCK_HALF);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCK_HALF - 1);
    localparam logic [4:0]         c_LAST_BIT = 5'(SAMPLE_WIDTH);

    logic [c_DIV_W-1:0]      r_div;
    logic                    r_sck;
    logic                    r_ws;
    logic [5:0]              r_bit_cnt;
    logic                    r_sync1;
    logic                    r_sync2;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic                    r_pend;

    logic                    w_div_tc;
    logic                    w_fall;
    logic [4:0]              w_slot_pos;
    logic                    w_chan;
    logic [5:0]              w_cnt_next;
    logic [SAMPLE_WIDTH-1:0] w_shift_next;

    assign w_div_tc     = (r_div == c_DIV_LAST);
    // Falling-edge event: end of the SCK high phase, where the bit is sampled.
    assign w_fall       = w_div_tc & r_sck;
    assign w_slot_pos   = r_bit_cnt[4:0];
    assign w_chan       = r_bit_cnt[5];
    assign w_cnt_next   = r_bit_cnt + 6'd1;
    assign w_shift_next = SAMPLE_WIDTH'({r_shift, r_sync2});

    assign mic_sck = r_sck;
    assign mic_ws  = r_ws;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div       <= '0;
            r_sck       <= 1'b0;
            r_ws        <= 1'b0;
            r_bit_cnt   <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_pend      <= 1'b0;
            audio_left  <= '0;
            audio_right <= '0;
            audio_valid <= 1'b0;
        end else begin
            r_sync1     <= mic_data;
            r_sync2     <= r_sync1;
            r_pend      <= 1'b0;
            audio_valid <= r_pend;

            if (r_pend) begin
                audio_left  <= r_left_hold;
                audio_right <= r_shift;
            end

            if (w_div_tc) begin
                r_div <= '0;
                r_sck <= ~r_sck;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_fall) begin
                r_bit_cnt <= w_cnt_next;
                r_ws      <= w_cnt_next[5];

                // Slot position 0 is the I2S delay bit; beyond the sample is padding.
                if (w_slot_pos == 5'd0) begin
                    r_shift <= '0;
                end else if (w_slot_pos <= c_LAST_BIT) begin
                    r_shift <= w_shift_next;
                end

                if (w_slot_pos == c_LAST_BIT) begin
                    if (!w_chan) begin
                        r_left_hold <= w_shift_next;
                    end else begin
                        r_pend <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_mic_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_mic_frontend
// Description : Directed bench for i2s_mic_frontend with behavioural mic models
//               at SCK_HALF=16 and SCK_HALF=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_mic_frontend;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic          data_a, data_b;
    logic          sck_a, sck_b, ws_a, ws_b, valid_a, valid_b;
    logic [W-1:0]  left_a, right_a, left_b, right_b;

    logic [W-1:0]  tx_left  [16];
    logic [W-1:0]  tx_right [16];
    logic          tx_pad   [16];
    logic [W-1:0]  sine     [8];

    logic [5:0]    mcnt_a, mcnt_b;
    logic [3:0]    mfr_a, mfr_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2s_mic_frontend #(.SCK_HALF(16), .SAMPLE_WIDTH(W)) u_dut_a (
        .clk_in(clk), .rst_in(rst_a), .mic_data(data_a),
        .mic_sck(sck_a), .mic_ws(ws_a),
        .audio_left(left_a), .audio_right(right_a), .audio_valid(valid_a)
    );

    i2s_mic_frontend #(.SCK_HALF(4), .SAMPLE_WIDTH(W)) u_dut_b (
        .clk_in(clk), .rst_in(rst_b), .mic_data(data_b),
        .mic_sck(sck_b), .mic_ws(ws_b),
        .audio_left(left_b), .audio_right(right_b), .audio_valid(valid_b)
    );

    function automatic logic mic_bit(input logic [3:0] f, input logic [5:0] b);
        logic [W-1:0] s;
        int           p;
        p = int'(b[4:0]);
        s = b[5] ? tx_right[f] : tx_left[f];
        if (p >= 1 && p <= W) return s[W-p];
        return tx_pad[f];
    endfunction

    // Microphone models: each bit is driven for the SCK period that follows a falling edge.
    always @(posedge rst_a or negedge sck_a) begin
        if (rst_a) begin
            mcnt_a = '0;
            mfr_a  = '0;
        end else begin
            mcnt_a = mcnt_a + 6'd1;
            if (mcnt_a == 6'd0) mfr_a = mfr_a + 4'd1;
        end
        data_a = mic_bit(mfr_a, mcnt_a);
    end

    always @(posedge rst_b or negedge sck_b) begin
        if (rst_b) begin
            mcnt_b = '0;
            mfr_b  = '0;
        end else begin
            mcnt_b = mcnt_b + 6'd1;
            if (mcnt_b == 6'd0) mfr_b = mfr_b + 4'd1;
        end
        data_b = mic_bit(mfr_b, mcnt_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Walks ncyc clocks after a reset release, comparing SCK/WS/valid against
    // closed-form timing and each strobed pair against the frame table.
    task automatic run_window(input bit sel, input int h, input int ncyc);
        int           first_valid, frame_len, n_valid, exp_n, k;
        int           bad_sck, bad_ws, bad_vld, first_rise;
        logic         sck, ws, vld, e_sck, e_ws, e_vld, prev_sck;
        logic [W-1:0] lft, rgt;
        first_valid = (32 + W + 1) * 2 * h + 1;
        frame_len   = 128 * h;
        n_valid     = 0;
        bad_sck     = 0;
        bad_ws      = 0;
        bad_vld     = 0;
        first_rise  = -1;
        prev_sck    = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            sck = sel ? sck_b   : sck_a;
            ws  = sel ? ws_b    : ws_a;
            vld = sel ? valid_b : valid_a;
            lft = sel ? left_b  : left_a;
            rgt = sel ? right_b : right_a;
            e_sck = ((c / h) % 2) == 1;
            e_ws  = ((c / (64 * h)) % 2) == 1;
            e_vld = (c >= first_valid) && (((c - first_valid) % frame_len) == 0);
            if (sck && !prev_sck && first_rise < 0) first_rise = c;
            prev_sck = sck;
            if (sck !== e_sck) bad_sck++;
            if (ws  !== e_ws)  bad_ws++;
            if (vld !== e_vld) bad_vld++;
            if (vld === 1'b1) n_valid++;
            if (e_vld) begin
                k = (c - first_valid) / frame_len;
                chk($sformatf("left[%0d] h=%0d", k, h),  32'(lft), 32'(tx_left[k]));
                chk($sformatf("right[%0d] h=%0d", k, h), 32'(rgt), 32'(tx_right[k]));
            end
        end
        exp_n = (ncyc >= first_valid) ? (ncyc - first_valid) / frame_len + 1 : 0;
        chk($sformatf("first_sck_rise h=%0d", h), 32'(first_rise), 32'(h));
        chk($sformatf("sck_bad_cycles h=%0d", h), 32'(bad_sck), 32'd0);
        chk($sformatf("ws_bad_cycles h=%0d", h),  32'(bad_ws),  32'd0);
        chk($sformatf("valid_bad_cycles h=%0d", h), 32'(bad_vld), 32'd0);
        chk($sformatf("valid_count h=%0d", h), 32'(n_valid), 32'(exp_n));
    endtask

    initial begin
        sine = '{24'h000000, 24'h106D28, 24'h2094B0, 24'h3030F0,
                 24'h3F0438, 24'h4CCB30, 24'h594CE0, 24'h6456A0};
        for (int i = 0; i < 16; i++) begin
            tx_left[i]  = '0;
            tx_right[i] = '0;
            tx_pad[i]   = 1'b0;
        end
        tx_left[0] = 24'h123456; tx_right[0] = 24'hABCDEF; tx_pad[0] = 1'b0;
        tx_left[1] = 24'h000000; tx_right[1] = 24'h800000; tx_pad[1] = 1'b1;
        tx_left[2] = 24'hFFFFFF; tx_right[2] = 24'h7FFFFF; tx_pad[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_left[3+i]  = sine[i];
            tx_right[3+i] = ~sine[i] + 24'd1;
            tx_pad[3+i]   = i[0];
        end

        rst_a = 1'b0;
        rst_b = 1'b0;
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset sck",   32'(sck_a),   32'd0);
        chk("reset ws",    32'(ws_a),    32'd0);
        chk("reset left",  32'(left_a),  32'd0);
        chk("reset right", 32'(right_a), 32'd0);
        chk("reset valid", 32'(valid_a), 32'd0);

        // Basic, padding, extremes and sine frames, then stop inside frame 11's right slot.
        @(negedge clk);
        rst_a = 1'b0;
        run_window(1'b0, 16, 11 * 2048 + 1500);

        rst_a = 1'b1;
        #1;
        chk("midrst sck",   32'(sck_a),   32'd0);
        chk("midrst ws",    32'(ws_a),    32'd0);
        chk("midrst valid", 32'(valid_a), 32'd0);
        chk("midrst left",  32'(left_a),  32'd0);
        chk("midrst right", 32'(right_a), 32'd0);
        tx_left[0] = 24'h13579B; tx_right[0] = 24'h2468AC; tx_pad[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        run_window(1'b0, 16, 1830);

        // Fast SCK instance: extremes first, then the basic and padding frames.
        tx_left[0] = 24'hFFFFFF; tx_right[0] = 24'h7FFFFF; tx_pad[0] = 1'b0;
        tx_left[1] = 24'h123456; tx_right[1] = 24'hABCDEF; tx_pad[1] = 1'b0;
        tx_left[2] = 24'h000000; tx_right[2] = 24'h800000; tx_pad[2] = 1'b1;
        @(posedge clk);
        #1;
        chk("reset b valid", 32'(valid_b), 32'd0);
        chk("reset b left",  32'(left_b),  32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        run_window(1'b1, 4, 457 + 2 * 512 + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
